// File: rtl/benes_cfg_loader.sv
// -----------------------------------------------------------------------------
// benes_cfg_loader
//   Streams per-stage switch-control words into a shadow bank over a
//   valid/ready handshake and commits the whole bank atomically to the active
//   switch_set[] array feeding the benes_32 fabric. A new permutation loads in
//   the background while the fabric keeps routing on the old one.
//
// Optional feature: define BENES_CFG_PARITY_EN to widen s_cfg_data by one MSB
//   even-parity bit; a word with odd total parity raises o_cfg_err and drops
//   the frame.
//
// Ports
//   clk          in   rising-edge clock
//   rstn         in   asynchronous active-low reset
//   s_cfg_valid  in   config word valid
//   s_cfg_ready  out  loader can accept a word (registered)
//   s_cfg_data   in   switch bits for the current stage, bit k = switch k, 1 = cross
//                     (plus MSB even-parity bit when BENES_CFG_PARITY_EN)
//   s_cfg_last   in   final word of a frame
//   i_swap       in   downstream permission to commit, sampled only while FULL
//   switch_set   out  active per-stage switch settings (registered)
//   o_pending    out  complete shadow frame waiting for i_swap
//   o_cfg_err    out  one-cycle pulse: frame length/parity error, frame dropped
//   o_commit     out  one-cycle pulse aligned with the updated switch_set
// -----------------------------------------------------------------------------
module benes_cfg_loader #(
    parameter int STAGE_NUM  = 9,
    parameter int SWITCH_NUM = 16,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_cfg_valid,
    output logic                  s_cfg_ready,
`ifdef BENES_CFG_PARITY_EN
    input  logic [SWITCH_NUM:0]   s_cfg_data,
`else
    input  logic [SWITCH_NUM-1:0] s_cfg_data,
`endif
    input  logic                  s_cfg_last,
    input  logic                  i_swap,
    output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1],
    output logic                  o_pending,
    output logic                  o_cfg_err,
    output logic                  o_commit
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_NUM - 1);

`ifdef BENES_CFG_PARITY_EN
    // Even parity over the whole word (data + parity bit): a set result means a bad word.
    function automatic logic parity_odd(input logic [SWITCH_NUM:0] w);
        return ^w;
    endfunction
`endif

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic [SWITCH_NUM-1:0]   shadow_r [0:STAGE_NUM-1];
    logic                    accept_s;
    logic                    parity_bad_s;
    logic                    shadow_we_s;
    logic                    load_s;
    logic                    err_nxt_s;

    assign accept_s = s_cfg_valid & s_cfg_ready;

`ifdef BENES_CFG_PARITY_EN
    assign parity_bad_s = parity_odd(s_cfg_data);
`else
    assign parity_bad_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, counter and pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = 1'b0;
        shadow_we_s = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    shadow_we_s = 1'b1;
                    if (parity_bad_s) begin
                        // Bad word: drop the frame; a last word needs no draining.
                        err_nxt_s   = 1'b1;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = s_cfg_last ? ST_FILL : ST_DRAIN;
                    end else if (s_cfg_last) begin
                        cnt_nxt_s = {CNT_W{1'b0}};
                        if (cnt_r == CNT_LAST) begin
                            state_nxt_s = ST_FULL;
                        end else begin
                            err_nxt_s   = 1'b1;
                            state_nxt_s = ST_FILL;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        // Frame too long: flag once here, swallow the rest in DRAIN.
                        err_nxt_s   = 1'b1;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (accept_s && s_cfg_last) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FULL: begin
                if (i_swap) begin
                    load_s      = 1'b1;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // Counter, shadow bank, active bank and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r       <= {CNT_W{1'b0}};
            s_cfg_ready <= 1'b0;
            o_pending   <= 1'b0;
            o_cfg_err   <= 1'b0;
            o_commit    <= 1'b0;
            for (int i = 0; i < STAGE_NUM; i++) begin
                shadow_r[i]   <= {SWITCH_NUM{1'b0}};
                switch_set[i] <= {SWITCH_NUM{1'b0}};
            end
        end else begin
            cnt_r       <= cnt_nxt_s;
            s_cfg_ready <= (state_nxt_s != ST_FULL);
            o_pending   <= (state_nxt_s == ST_FULL);
            o_cfg_err   <= err_nxt_s;
            o_commit    <= load_s;
            if (shadow_we_s) begin
                shadow_r[cnt_r] <= s_cfg_data[SWITCH_NUM-1:0];
            end
            // All stages change on the same edge, so the fabric never sees a mixed frame.
            if (load_s) begin
                for (int i = 0; i < STAGE_NUM; i++) begin
                    switch_set[i] <= shadow_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_benes_cfg_loader.sv
module tb_benes_cfg_loader;

`ifdef BENES_CFG_PARITY_EN
    localparam int DW = 17;
`else
    localparam int DW = 16;
`endif

    logic          clk;
    logic          rstn;
    logic          s_cfg_valid;
    logic          s_cfg_ready;
    logic [DW-1:0] s_cfg_data;
    logic          s_cfg_last;
    logic          i_swap;
    logic [15:0]   switch_set [0:8];
    logic          o_pending;
    logic          o_cfg_err;
    logic          o_commit;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] frame_a [9];
    logic [15:0] frame_b [9];
    logic [15:0] frame_z [9];

    benes_cfg_loader #(
        .STAGE_NUM (9),
        .SWITCH_NUM(16),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_cfg_valid(s_cfg_valid),
        .s_cfg_ready(s_cfg_ready),
        .s_cfg_data (s_cfg_data),
        .s_cfg_last (s_cfg_last),
        .i_swap     (i_swap),
        .switch_set (switch_set),
        .o_pending  (o_pending),
        .o_cfg_err  (o_cfg_err),
        .o_commit   (o_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] e [9]);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(switch_set[i]), 32'(e[i]));
        end
    endtask

    // Presents one word at a negedge and returns at the negedge after it was accepted.
    task automatic send(input logic [15:0] d, input logic last, input logic flip);
        logic acc;
        int   t;
        s_cfg_valid = 1'b1;
        s_cfg_last  = last;
`ifdef BENES_CFG_PARITY_EN
        s_cfg_data  = {(^d) ^ flip, d};
`else
        s_cfg_data  = d;
        if (flip) s_cfg_data = d;
`endif
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 50) begin
            acc = s_cfg_ready;
            @(negedge clk);
            t++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        s_cfg_valid = 1'b0;
        s_cfg_last  = 1'b0;
    endtask

    initial begin
        frame_a = '{16'hA300, 16'h00A8, 16'hE0E4, 16'h183C, 16'h1014,
                    16'h1014, 16'h2020, 16'h2810, 16'h2D00};
        frame_b = '{16'h0001, 16'h8002, 16'h4004, 16'h2008, 16'h1010,
                    16'h0820, 16'h0440, 16'h0280, 16'hFFFF};
        frame_z = '{default: 16'h0000};

        rstn        = 1'b0;
        s_cfg_valid = 1'b0;
        s_cfg_data  = '0;
        s_cfg_last  = 1'b0;
        i_swap      = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_ready",   32'(s_cfg_ready), 32'd0);
        chk("rst_pending", 32'(o_pending),   32'd0);
        chk("rst_err",     32'(o_cfg_err),   32'd0);
        chk("rst_commit",  32'(o_commit),    32'd0);
        chk_frame("rst_sw", frame_z);
        rstn = 1'b1;
        chk("rel_ready_low", 32'(s_cfg_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_high", 32'(s_cfg_ready), 32'd1);

        // Frame A, held pending until i_swap
        for (int i = 0; i < 9; i++) send(frame_a[i], i == 8, 1'b0);
        chk("a_pending", 32'(o_pending),   32'd1);
        chk("a_ready",   32'(s_cfg_ready), 32'd0);
        chk("a_err",     32'(o_cfg_err),   32'd0);
        chk_frame("a_nocommit", frame_z);
        repeat (3) @(negedge clk);
        chk("a_still_pending", 32'(o_pending), 32'd1);
        chk("a_no_commit",     32'(o_commit),  32'd0);
        i_swap = 1'b1;
        @(negedge clk);
        i_swap = 1'b0;
        chk("a_commit",       32'(o_commit),    32'd1);
        chk("a_pending_clr",  32'(o_pending),   32'd0);
        chk("a_ready_back",   32'(s_cfg_ready), 32'd1);
        chk_frame("a_sw", frame_a);
        @(negedge clk);
        chk("a_commit_pulse", 32'(o_commit), 32'd0);

        // Short frame: last on the 4th word
        for (int i = 0; i < 3; i++) send(16'h5555, 1'b0, 1'b0);
        chk("short_no_err_yet", 32'(o_cfg_err), 32'd0);
        send(16'h5555, 1'b1, 1'b0);
        chk("short_err",     32'(o_cfg_err), 32'd1);
        chk("short_pending", 32'(o_pending), 32'd0);
        @(negedge clk);
        chk("short_err_pulse", 32'(o_cfg_err), 32'd0);
        chk_frame("short_sw", frame_a);

        // Valid frame B after the short one
        for (int i = 0; i < 9; i++) send(frame_b[i], i == 8, 1'b0);
        chk("b_pending", 32'(o_pending), 32'd1);
        i_swap = 1'b1;
        @(negedge clk);
        i_swap = 1'b0;
        chk("b_commit", 32'(o_commit), 32'd1);
        chk_frame("b_sw", frame_b);

        // Long frame: 11 words
        for (int i = 0; i < 8; i++) send(16'h3333, 1'b0, 1'b0);
        chk("long_no_err_yet", 32'(o_cfg_err), 32'd0);
        send(16'h3333, 1'b0, 1'b0);
        chk("long_err_9th", 32'(o_cfg_err), 32'd1);
        send(16'h7777, 1'b0, 1'b0);
        chk("long_drain_err",   32'(o_cfg_err),   32'd0);
        chk("long_drain_ready", 32'(s_cfg_ready), 32'd1);
        send(16'h7777, 1'b1, 1'b0);
        chk("long_end_err",     32'(o_cfg_err), 32'd0);
        chk("long_end_pending", 32'(o_pending), 32'd0);
        chk_frame("long_sw", frame_b);

        // Gapped frame A with i_swap held high during FILL
        i_swap = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(frame_a[i], i == 8, 1'b0);
            if (i < 8) begin
                chk($sformatf("gap_commit_%0d", i), 32'(o_commit), 32'd0);
                chk($sformatf("gap_sw0_%0d", i), 32'(switch_set[0]), 32'h0000_0001);
                repeat (i % 3) @(negedge clk);
            end
        end
        chk("gap_pending",   32'(o_pending), 32'd1);
        chk("gap_no_commit", 32'(o_commit),  32'd0);
        @(negedge clk);
        i_swap = 1'b0;
        chk("gap_commit", 32'(o_commit), 32'd1);
        chk_frame("gap_sw", frame_a);

        // Frame B streamed straight after the commit
        send(frame_b[0], 1'b0, 1'b0);
        chk("bb_sw0_hold", 32'(switch_set[0]), 32'h0000_A300);
        for (int i = 1; i < 9; i++) send(frame_b[i], i == 8, 1'b0);
        chk("bb_pending", 32'(o_pending), 32'd1);
        i_swap = 1'b1;
        @(negedge clk);
        i_swap = 1'b0;
        chk("bb_commit", 32'(o_commit), 32'd1);
        chk_frame("bb_sw", frame_b);

`ifdef BENES_CFG_PARITY_EN
        // Parity error on word 3 drops the frame
        for (int i = 0; i < 9; i++) begin
            send(frame_a[i], i == 8, i == 2);
            if (i == 2) chk("par_err", 32'(o_cfg_err), 32'd1);
        end
        chk("par_err_once", 32'(o_cfg_err), 32'd0);
        chk("par_pending",  32'(o_pending), 32'd0);
        chk_frame("par_sw", frame_b);
`endif

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) send(frame_a[i], 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready",   32'(s_cfg_ready), 32'd0);
        chk("mid_rst_pending", 32'(o_pending),   32'd0);
        chk_frame("mid_rst_sw", frame_z);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 32'(s_cfg_ready), 32'd1);

        // The aborted frame must not leak into the next one
        for (int i = 0; i < 9; i++) send(frame_b[i], i == 8, 1'b0);
        i_swap = 1'b1;
        @(negedge clk);
        i_swap = 1'b0;
        chk("post_rst_commit", 32'(o_commit), 32'd1);
        chk_frame("post_rst_sw", frame_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
